// File: rtl/regfile_arbiter.sv
// regfile_arbiter
//   Two-requester round-robin front end for a 32 x 8-bit register file.
//   One command is in flight at a time. A granted command walks through
//   ISSUE (register file strobe), CAPTURE (read data returns) and RESP
//   (one-cycle ack to the owner), then the arbiter is free again.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata requester A command (we: 1 = write, 0 = read)
//   a_gnt                     A command accepted this cycle (IDLE only)
//   a_ack, a_rdata            A completion pulse and held read result
//   b_*                       same set for requester B
//   busy                      high whenever a command is in flight
//   rf_valid                  register file {write, read1, read2} strobes
//   rf_read_addr_1            read port 1 address (captured addr)
//   rf_read_addr_2            unused read port, tied to 0
//   rf_write_addr/_data       write port address and data (captured command)
//   rf_read_1                 registered read port 1 data from the register file
//
// Build option
//   REGFILE_ARB_REG0_PROTECT_EN: writes to address 0 complete and are acked
//   but never strobe the register file, so register 0 stays 0.

module regfile_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_gnt,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_gnt,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       busy,
  output logic [2:0] rf_valid,
  output logic [4:0] rf_read_addr_1,
  output logic [4:0] rf_read_addr_2,
  output logic [4:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  input  logic [7:0] rf_read_1
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StCapture = 2'd2,
    StResp    = 2'd3
  } state_e;

  state_e     r_state;
  state_e     w_state_next;

  // Captured command; r_owner_b marks which requester owns it.
  logic       r_we;
  logic [4:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_owner_b;
  // Last requester granted; resets to B so A wins the first tie.
  logic       r_last_b;

  logic [7:0] r_a_rdata;
  logic [7:0] r_b_rdata;

  logic       w_a_gnt;
  logic       w_b_gnt;
  logic       w_xfer;
  logic       w_a_ack;
  logic       w_b_ack;
  logic       w_busy;
  logic [2:0] w_rf_valid;
  logic       w_wr_en;

`ifdef REGFILE_ARB_REG0_PROTECT_EN
  assign w_wr_en = (r_addr != 5'd0);
`else
  assign w_wr_en = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, grants, strobes and acks
  always_comb begin
    w_state_next = r_state;
    w_a_gnt      = 1'b0;
    w_b_gnt      = 1'b0;
    w_a_ack      = 1'b0;
    w_b_ack      = 1'b0;
    w_busy       = 1'b1;
    w_rf_valid   = 3'b000;
    unique case (r_state)
      StIdle: begin
        w_busy  = 1'b0;
        // On a tie the requester not granted last wins.
        w_a_gnt = a_req & (~b_req | r_last_b);
        w_b_gnt = b_req & (~a_req | ~r_last_b);
        if (w_a_gnt || w_b_gnt) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_rf_valid   = r_we ? {w_wr_en, 2'b00} : 3'b010;
        w_state_next = StCapture;
      end
      StCapture: begin
        w_state_next = StResp;
      end
      StResp: begin
        w_a_ack      = ~r_owner_b;
        w_b_ack      = r_owner_b;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign w_xfer = w_a_gnt | w_b_gnt;

  // Command capture on the transfer edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= 5'd0;
      r_wdata   <= 8'd0;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
    end else if (w_xfer) begin
      r_we      <= w_b_gnt ? b_we    : a_we;
      r_addr    <= w_b_gnt ? b_addr  : a_addr;
      r_wdata   <= w_b_gnt ? b_wdata : a_wdata;
      r_owner_b <= w_b_gnt;
      r_last_b  <= w_b_gnt;
    end
  end

  // Read data is registered in the register file during ISSUE, so it is
  // present on rf_read_1 throughout CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rdata <= 8'd0;
      r_b_rdata <= 8'd0;
    end else if (r_state == StCapture && !r_we) begin
      if (r_owner_b) begin
        r_b_rdata <= rf_read_1;
      end else begin
        r_a_rdata <= rf_read_1;
      end
    end
  end

  assign a_gnt          = w_a_gnt;
  assign b_gnt          = w_b_gnt;
  assign a_ack          = w_a_ack;
  assign b_ack          = w_b_ack;
  assign a_rdata        = r_a_rdata;
  assign b_rdata        = r_b_rdata;
  assign busy           = w_busy;
  assign rf_valid       = w_rf_valid;
  assign rf_read_addr_1 = r_addr;
  assign rf_read_addr_2 = 5'd0;
  assign rf_write_addr  = r_addr;
  assign rf_write_data  = r_wdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: table of single-requester transactions, a few
// hand-written multi-cycle sequences, and random traffic, all checked every
// cycle against a transaction-level reference model.

module tb_regfile_arbiter;

`ifdef REGFILE_ARB_REG0_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0;
  logic       a_gnt, a_ack, b_gnt, b_ack, busy;
  logic [7:0] a_rdata, b_rdata;
  logic [2:0] rf_valid;
  logic [4:0] rf_read_addr_1, rf_read_addr_2, rf_write_addr;
  logic [7:0] rf_write_data;
  logic [7:0] rf_read_1 = 8'h00;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .a_req          (a_req),
    .a_we           (a_we),
    .a_addr         (a_addr),
    .a_wdata        (a_wdata),
    .a_gnt          (a_gnt),
    .a_ack          (a_ack),
    .a_rdata        (a_rdata),
    .b_req          (b_req),
    .b_we           (b_we),
    .b_addr         (b_addr),
    .b_wdata        (b_wdata),
    .b_gnt          (b_gnt),
    .b_ack          (b_ack),
    .b_rdata        (b_rdata),
    .busy           (busy),
    .rf_valid       (rf_valid),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_read_1      (rf_read_1)
  );

  // Register file environment: registered read, unaffected by rst.
  bit [7:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_valid[2]) rf_mem[rf_write_addr] <= rf_write_data;
    if (rf_valid[1]) rf_read_1 <= rf_mem[rf_read_addr_1];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles left in the current transaction (3 = ISSUE,
  // 2 = CAPTURE, 1 = RESP, 0 = free), the captured command and a memory image.
  int         m_cnt;
  bit         m_owner_b, m_last_b, m_we;
  logic [4:0] m_addr;
  logic [7:0] m_wdata, m_a_rdata, m_b_rdata;
  bit   [7:0] m_mem [32];

  logic       o_a_gnt, o_b_gnt, o_a_ack, o_b_ack;
  logic [7:0] o_a_rdata, o_b_rdata;

  task automatic model_reset();
    m_cnt = 0; m_owner_b = 0; m_last_b = 1; m_we = 0;
    m_addr = '0; m_wdata = '0; m_a_rdata = '0; m_b_rdata = '0;
  endtask

  task automatic step(input bit ar, input bit aw, input logic [4:0] aa, input logic [7:0] ad,
                      input bit br, input bit bw, input logic [4:0] ba, input logic [7:0] bd);
    bit ea, eb;
    logic [2:0] ev;
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    ea = (m_cnt == 0) && ar && (!br || m_last_b);
    eb = (m_cnt == 0) && br && (!ar || !m_last_b);
    ev = 3'b000;
    if (m_cnt == 3) ev = m_we ? ((Prot && m_addr == 5'd0) ? 3'b000 : 3'b100) : 3'b010;
    chk("a_gnt", 32'(a_gnt), 32'(ea));
    chk("b_gnt", 32'(b_gnt), 32'(eb));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("rf_valid", 32'(rf_valid), 32'(ev));
    chk("a_ack", 32'(a_ack), 32'(m_cnt == 1 && !m_owner_b));
    chk("b_ack", 32'(b_ack), 32'(m_cnt == 1 && m_owner_b));
    chk("a_rdata", 32'(a_rdata), 32'(m_a_rdata));
    chk("b_rdata", 32'(b_rdata), 32'(m_b_rdata));
    chk("rf_read_addr_1", 32'(rf_read_addr_1), 32'(m_addr));
    chk("rf_read_addr_2", 32'(rf_read_addr_2), 32'd0);
    chk("rf_write_addr", 32'(rf_write_addr), 32'(m_addr));
    chk("rf_write_data", 32'(rf_write_data), 32'(m_wdata));
    o_a_gnt = a_gnt; o_b_gnt = b_gnt; o_a_ack = a_ack; o_b_ack = b_ack;
    o_a_rdata = a_rdata; o_b_rdata = b_rdata;
    @(posedge clk);
    if (m_cnt == 3 && m_we && !(Prot && m_addr == 5'd0)) m_mem[m_addr] = m_wdata;
    if (m_cnt == 2 && !m_we) begin
      if (m_owner_b) m_b_rdata = m_mem[m_addr];
      else           m_a_rdata = m_mem[m_addr];
    end
    if (m_cnt != 0) begin
      m_cnt--;
    end else if (ea || eb) begin
      m_cnt = 3; m_owner_b = eb; m_last_b = eb;
      m_we = eb ? bw : aw; m_addr = eb ? ba : aa; m_wdata = eb ? bd : ad;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  // Asserts rst at the next falling edge; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rf_valid", 32'(rf_valid), 32'd0);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_a_rdata", 32'(a_rdata), 32'd0);
    chk("rst_b_rdata", 32'(b_rdata), 32'd0);
    chk("rst_addr", 32'(rf_write_addr), 32'd0);
    chk("rst_wdata", 32'(rf_write_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One uncontended transaction: grant on the first cycle, ack 3 cycles later.
  task automatic do_txn(input bit is_b, input bit we, input logic [4:0] addr,
                        input logic [7:0] wdata, input bit chk_rd, input logic [7:0] exp_rd,
                        input string tag);
    int waited = 0;
    int lat = 0;
    bit granted = 0;
    bit acked = 0;
    while (!granted && waited < 20) begin
      if (is_b) step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, we, addr, wdata);
      else      step(1'b1, we, addr, wdata, 1'b0, 1'b0, 5'd0, 8'd0);
      granted = is_b ? o_b_gnt : o_a_gnt;
      waited++;
    end
    chk({tag, "_grant_wait"}, 32'(waited), 32'd1);
    if (!granted) return;
    while (!acked && lat < 10) begin
      idle();
      lat++;
      acked = is_b ? o_b_ack : o_a_ack;
    end
    chk({tag, "_ack_latency"}, 32'(lat), 32'd3);
    if (chk_rd) chk({tag, "_rdata"}, 32'(is_b ? o_b_rdata : o_a_rdata), 32'(exp_rd));
  endtask

  typedef struct {
    bit         is_b;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
    bit         chk_rd;
    logic [7:0] exp_rd;
  } txn_t;

  txn_t tbl [14];

  initial begin
    bit         q [$];
    int         cyc;
    logic [7:0] reg0_exp;

    reg0_exp = Prot ? 8'h00 : 8'hFF;
    tbl[0]  = '{0, 1, 5'd5,  8'hA5, 0, 8'h00};
    tbl[1]  = '{0, 0, 5'd5,  8'h00, 1, 8'hA5};
    tbl[2]  = '{0, 1, 5'd0,  8'hFF, 0, 8'h00};
    tbl[3]  = '{0, 0, 5'd0,  8'h00, 1, reg0_exp};
    tbl[4]  = '{1, 1, 5'd1,  8'h11, 0, 8'h00};
    tbl[5]  = '{1, 1, 5'd2,  8'h22, 0, 8'h00};
    tbl[6]  = '{1, 1, 5'd3,  8'h33, 0, 8'h00};
    tbl[7]  = '{1, 1, 5'd4,  8'h44, 0, 8'h00};
    tbl[8]  = '{1, 0, 5'd1,  8'h00, 1, 8'h11};
    tbl[9]  = '{1, 0, 5'd2,  8'h00, 1, 8'h22};
    tbl[10] = '{0, 0, 5'd3,  8'h00, 1, 8'h33};
    tbl[11] = '{1, 0, 5'd4,  8'h00, 1, 8'h44};
    tbl[12] = '{1, 1, 5'd9,  8'h5A, 0, 8'h00};
    tbl[13] = '{0, 0, 5'd9,  8'h00, 1, 8'h5A};

    model_reset();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      do_txn(tbl[i].is_b, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].chk_rd,
             tbl[i].exp_rd, $sformatf("tbl%0d", i));
    end

    // B writes 31 while A keeps requesting: A waits out the whole transaction.
    do_reset();
    step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 5'd31, 8'h3C);
    chk("b31_gnt", 32'(o_b_gnt), 32'd1);
    cyc = 0;
    o_a_gnt = 1'b0;
    while (!o_a_gnt && cyc < 20) begin
      step(1'b1, 1'b0, 5'd31, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
      cyc++;
    end
    chk("a_wait_cycles", 32'(cyc), 32'd4);
    idle(); idle(); idle();
    chk("a31_ack", 32'(o_a_ack), 32'd1);
    chk("a31_rdata", 32'(o_a_rdata), 32'h3C);

    // Both requesters reading from reset: grants alternate A, B, A, B.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 5'd5, 8'd0, 1'b1, 1'b0, 5'd1, 8'd0);
      if (o_a_gnt) q.push_back(1'b0);
      if (o_b_gnt) q.push_back(1'b1);
    end
    chk("rr_grant_count", 32'(q.size()), 32'd4);
    for (int i = 0; i < q.size() && i < 4; i++) begin
      chk($sformatf("rr_grant%0d_is_b", i), 32'(q[i]), 32'(i % 2));
    end
    idle(); idle(); idle();

    // Reset during CAPTURE of an A read.
    do_txn(1'b0, 1'b0, 5'd5, 8'd0, 1'b1, 8'hA5, "pre_abort");
    step(1'b1, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 5'd0, 8'd0);
    chk("abort_gnt", 32'(o_a_gnt), 32'd1);
    idle();
    do_reset();
    for (int i = 0; i < 5; i++) idle();

    // Reset during ISSUE of a write suppresses it.
    step(1'b0, 1'b0, 5'd0, 8'd0, 1'b1, 1'b1, 5'd7, 8'h77);
    chk("supp_gnt", 32'(o_b_gnt), 32'd1);
    do_reset();
    do_txn(1'b0, 1'b0, 5'd7, 8'd0, 1'b1, 8'h00, "suppressed_write");

    // Random traffic on a small address range so reads hit earlier writes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 8'($urandom));
      end
    end
    for (int i = 0; i < 5; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
